// File: rtl/tube_pkg.sv
// Shared types and default timing constants for the key counter / display-driver slice.
// Consumers: key_debounce, key_count_ctrl (build option KEY_AUTOREPEAT_EN).
package tube_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } deb_state_e;

  localparam int DEF_DEB_CYCLES = 20000;
  localparam int DEF_RPT_DELAY  = 500000;
  localparam int DEF_RPT_PERIOD = 100000;
  localparam int DEF_MAX_VAL    = 255;
  localparam int TUBE_W         = 8;

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-flop synchronizer, debounce FSM, one-cycle press pulse.
// With KEY_AUTOREPEAT_EN defined and RPT_EN set, a held key also emits repeat pulses.
module key_debounce
  import tube_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
`ifdef KEY_AUTOREPEAT_EN
  , parameter int RPT_DELAY  = DEF_RPT_DELAY
  , parameter int RPT_PERIOD = DEF_RPT_PERIOD
  , parameter bit RPT_EN     = 1'b1
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_pulse
);

  localparam int               DEB_W    = $clog2(DEB_CYCLES + 1);
  // The sample that enters a check state is the first stable one, hence -2.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 2);
  localparam logic [DEB_W-1:0] DEB_SAT  = '1;

  logic [1:0]       r_sync;
  deb_state_e       r_state;
  deb_state_e       w_state_nxt;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [DEB_W-1:0] w_deb_cnt_nxt;
  logic             r_pulse;
  logic             w_press;
  logic             w_pulse_nxt;
  logic             w_key_low;

  assign w_key_low = ~r_sync[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_state   <= ST_IDLE;
      r_deb_cnt <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key_n};
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_cnt_nxt;
      r_pulse   <= w_pulse_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_press       = 1'b0;
    w_deb_cnt_nxt = (r_deb_cnt == DEB_SAT) ? r_deb_cnt : r_deb_cnt + 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_key_low) w_state_nxt = ST_PRESS_CHK;
      end
      ST_PRESS_CHK: begin
        if (!w_key_low) begin
          w_state_nxt = ST_IDLE;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt = ST_HELD;
          w_press     = 1'b1;
        end
      end
      ST_HELD: begin
        if (!w_key_low) w_state_nxt = ST_REL_CHK;
      end
      ST_REL_CHK: begin
        if (w_key_low) begin
          w_state_nxt = ST_HELD;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt != r_state) w_deb_cnt_nxt = '0;
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(((RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD) + 1);
  logic w_rpt;

  if (RPT_EN) begin : g_rpt
    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_rpt_armed;
    logic [RPT_W-1:0] w_rpt_inc;
    logic [RPT_W-1:0] w_rpt_target;
    logic             w_hold_tick;

    // The timer only advances on cycles that stay in HELD; REL_CHK freezes it.
    assign w_hold_tick  = (r_state == ST_HELD) && w_key_low;
    assign w_rpt_inc    = r_rpt_cnt + 1'b1;
    assign w_rpt_target = r_rpt_armed ? RPT_W'(RPT_PERIOD) : RPT_W'(RPT_DELAY);
    assign w_rpt        = w_hold_tick && (w_rpt_inc == w_rpt_target);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rpt_cnt   <= '0;
        r_rpt_armed <= 1'b0;
      end else if (r_state == ST_IDLE || r_state == ST_PRESS_CHK) begin
        r_rpt_cnt   <= '0;
        r_rpt_armed <= 1'b0;
      end else if (w_hold_tick) begin
        if (w_rpt) begin
          r_rpt_cnt   <= '0;
          r_rpt_armed <= 1'b1;
        end else begin
          r_rpt_cnt <= w_rpt_inc;
        end
      end
    end
  end else begin : g_no_rpt
    assign w_rpt = 1'b0;
  end

  assign w_pulse_nxt = w_press | w_rpt;
`else
  assign w_pulse_nxt = w_press;
`endif

  assign o_pulse = r_pulse;

endmodule

// File: rtl/key_count_ctrl.sv
// Up/down/clear key counter feeding the 4-digit tube decoder; wraps within 0..MAX_VAL.
// Build option KEY_AUTOREPEAT_EN enables auto-repeat on the up and down keys.
module key_count_ctrl
  import tube_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD,
  parameter int MAX_VAL    = DEF_MAX_VAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_up_n,
  input  logic              key_dn_n,
  input  logic              key_clr_n,
  output logic [TUBE_W-1:0] data_tube,
  output logic              data_chg
);

  if (DEB_CYCLES < 2 || RPT_DELAY < 1 || RPT_PERIOD < 1 || MAX_VAL < 1 || MAX_VAL > 255)
  begin : g_bad_cfg
    $error("key_count_ctrl: parameter out of range");
  end

  localparam logic [TUBE_W-1:0] MAX_CNT = TUBE_W'(MAX_VAL);

  logic              w_up;
  logic              w_dn;
  logic              w_clr;
  logic [TUBE_W-1:0] r_tube;
  logic [TUBE_W-1:0] w_tube_nxt;
  logic              r_chg;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
    , .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD), .RPT_EN(1'b1)
`endif
  ) u_key_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_key_n(key_up_n),
    .o_pulse(w_up)
  );

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
    , .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD), .RPT_EN(1'b1)
`endif
  ) u_key_dn (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_key_n(key_dn_n),
    .o_pulse(w_dn)
  );

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
    , .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD), .RPT_EN(1'b0)
`endif
  ) u_key_clr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_key_n(key_clr_n),
    .o_pulse(w_clr)
  );

  // Clear wins; simultaneous up and down cancel out.
  always_comb begin
    w_tube_nxt = r_tube;
    if (w_clr) begin
      w_tube_nxt = '0;
    end else if (w_up && !w_dn) begin
      w_tube_nxt = (r_tube == MAX_CNT) ? '0 : r_tube + 1'b1;
    end else if (w_dn && !w_up) begin
      w_tube_nxt = (r_tube == '0) ? MAX_CNT : r_tube - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tube <= '0;
      r_chg  <= 1'b0;
    end else begin
      r_tube <= w_tube_nxt;
      r_chg  <= (w_tube_nxt != r_tube);
    end
  end

  assign data_tube = r_tube;
  assign data_chg  = r_chg;

endmodule

// File: tb/tb_key_count_ctrl.sv
// Self-checking bench for key_count_ctrl (DEB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3, MAX_VAL=255).
// Table of key presses plus hand sequences for timing, auto-repeat (KEY_AUTOREPEAT_EN) and reset.
module tb_key_count_ctrl;

  logic       clk;
  logic       rst_n;
  logic       key_up_n;
  logic       key_dn_n;
  logic       key_clr_n;
  logic [7:0] data_tube;
  logic       data_chg;

  key_count_ctrl #(
    .DEB_CYCLES(4),
    .RPT_DELAY (10),
    .RPT_PERIOD(3),
    .MAX_VAL   (255)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_up_n (key_up_n),
    .key_dn_n (key_dn_n),
    .key_clr_n(key_clr_n),
    .data_tube(data_tube),
    .data_chg (data_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] val;
    int         cyc;
  } obs_t;

  typedef struct packed {
    bit         up;
    bit         dn;
    bit         clr;
    int         low_cyc;
    bit         exp_chg;
    logic [7:0] exp_val;
  } vec_t;

  obs_t       obs_q[$];
  logic [7:0] exp_q[$];
  vec_t       vecs[24];
  int         n_checks = 0;
  int         n_errors = 0;
  int         start_cyc = 0;
  logic [7:0] model = 8'd0;

  always @(negedge clk) begin
    if (data_chg !== 1'b0) obs_q.push_back(obs_t'{data_tube, cyc});
  end

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic drive_keys(bit up, bit dn, bit clr, int low_cyc);
    @(negedge clk);
    key_up_n  = ~up;
    key_dn_n  = ~dn;
    key_clr_n = ~clr;
    start_cyc = cyc;
    repeat (low_cyc) @(negedge clk);
    key_up_n  = 1'b1;
    key_dn_n  = 1'b1;
    key_clr_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic drain(string tag);
    obs_t       o;
    logic [7:0] e;
    check({tag, " pulse count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " value"}, o.val, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic press_up_expect;
    model = (model == 8'd255) ? 8'd0 : model + 8'd1;
    exp_q.push_back(model);
    drive_keys(1'b1, 1'b0, 1'b0, 6);
    drain("step up");
  endtask

  initial begin
    rst_n     = 1'b0;
    key_up_n  = 1'b1;
    key_dn_n  = 1'b1;
    key_clr_n = 1'b1;

    //           up    dn    clr   low exp_chg value
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 6, 1'b1, 8'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 3, 1'b0, 8'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 6, 1'b1, 8'd2};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 6, 1'b1, 8'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 6, 1'b1, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 6, 1'b1, 8'd255};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 6, 1'b1, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 6, 1'b1, 8'd255};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 6, 1'b1, 8'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 6, 1'b0, 8'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 6, 1'b1, 8'd1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 6, 1'b1, 8'd2};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 6, 1'b1, 8'd3};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 6, 1'b1, 8'd4};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 6, 1'b1, 8'd5};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 6, 1'b1, 8'd0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 6, 1'b1, 8'd1};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 6, 1'b0, 8'd1};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 6, 1'b1, 8'd0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 2, 1'b0, 8'd0};
    vecs[20] = '{1'b1, 1'b1, 1'b1, 6, 1'b0, 8'd0};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 3, 1'b0, 8'd0};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 4, 1'b1, 8'd255};
    vecs[23] = '{1'b1, 1'b0, 1'b0, 4, 1'b1, 8'd0};

    repeat (3) @(negedge clk);
    check("reset data_tube", data_tube, 0);
    check("reset data_chg", data_chg, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    obs_q.delete();

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].exp_chg) exp_q.push_back(vecs[i].exp_val);
      drive_keys(vecs[i].up, vecs[i].dn, vecs[i].clr, vecs[i].low_cyc);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d final data_tube", i), data_tube, vecs[i].exp_val);
    end
    model = 8'd0;

`ifdef KEY_AUTOREPEAT_EN
    // Held 30 cycles: press lands 7 cycles after the edge, repeats 10 then every 3 cycles later.
    drive_keys(1'b1, 1'b0, 1'b0, 30);
    check("autorepeat pulse count", obs_q.size(), 7);
    for (int k = 0; k < 7 && k < obs_q.size(); k++) begin
      check($sformatf("autorepeat value %0d", k), obs_q[k].val, k + 1);
      check($sformatf("autorepeat offset %0d", k), obs_q[k].cyc - start_cyc,
            (k == 0) ? 7 : 7 + 10 + 3 * (k - 1));
    end
    obs_q.delete();
    model = 8'd7;
    check("autorepeat stops on release", data_tube, 7);
`else
    // Long hold without auto-repeat: one step, landing 7 cycles after the falling edge.
    drive_keys(1'b1, 1'b0, 1'b0, 20);
    check("long hold pulse count", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      check("long hold value", obs_q[0].val, 1);
      check("long hold latency", obs_q[0].cyc - start_cyc, 7);
    end
    obs_q.delete();
    model = 8'd1;
`endif

    while (model != 8'd9) press_up_expect();
    check("pre-reset data_tube", data_tube, 9);

    // Reset in the middle of PRESS_CHK: count clears at once and the press is lost.
    @(negedge clk);
    key_up_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset data_tube", data_tube, 0);
    check("async reset data_chg", data_chg, 0);
    key_up_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("aborted press pulses", obs_q.size(), 0);
    check("aborted press data_tube", data_tube, 0);
    obs_q.delete();

    // Key held through reset release: one step, 2 + DEB_CYCLES + 1 cycles after release.
    @(negedge clk);
    key_up_n = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    start_cyc = cyc;
    repeat (10) @(negedge clk);
    key_up_n = 1'b1;
    repeat (12) @(negedge clk);
    check("held-through-reset pulse count", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      check("held-through-reset value", obs_q[0].val, 1);
      check("held-through-reset latency", obs_q[0].cyc - start_cyc, 7);
    end
    obs_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_count_ctrl.md
KEY_COUNT_CTRL -- requirements
Module: key_count_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 20000, is the number of consecutive stable sampled cycles needed to accept a key level change.
REQ-002 Parameter RPT_DELAY, default 500000, is the number of held cycles after an accepted press before the first auto-repeat.
REQ-003 Parameter RPT_PERIOD, default 100000, is the number of cycles between subsequent auto-repeats.
REQ-004 Parameter MAX_VAL, default 255, is the upper count bound (range 1..255).
REQ-005 Ports: clk  in  1  system clock; all logic on its rising edge.
REQ-006 Ports: rst_n  in  1  reset; asynchronous, active-low.
REQ-007 Ports: key_up_n  in  1  raw increment button, active-low, asynchronous to clk.
REQ-008 Ports: key_dn_n  in  1  raw decrement button, active-low, asynchronous to clk.
REQ-009 Ports: key_clr_n  in  1  raw clear button, active-low, asynchronous to clk.
REQ-010 Ports: data_tube  out  8  current count, registered, fed directly to the 4-digit display decoder.
REQ-011 Ports: data_chg  out  1  one-cycle pulse in the cycle data_tube takes a new value.

Function
REQ-012 Each key passes through a 2-flop synchronizer before debounce; raw-to-debounced latency is 2 + DEB_CYCLES cycles.
REQ-013 Per-key debounce FSM states: IDLE, PRESS_CHK, HELD, REL_CHK.
REQ-014 IDLE->PRESS_CHK on synced low; PRESS_CHK->IDLE if input returns high before DEB_CYCLES; PRESS_CHK->HELD after DEB_CYCLES consecutive low samples, emitting one press pulse.
REQ-015 HELD->REL_CHK on synced high; REL_CHK->HELD if input returns low before DEB_CYCLES; REL_CHK->IDLE after DEB_CYCLES consecutive high samples; release emits no pulse.
REQ-016 The stability counter restarts at 0 on every state entry and saturates, never wrapping.
REQ-017 Increment: data_tube == MAX_VAL goes to 0; otherwise +1.
REQ-018 Decrement: data_tube == 0 goes to MAX_VAL; otherwise -1.
REQ-019 Clear pulse sets data_tube to 0 and has priority over up/down in the same cycle.
REQ-020 Up and down pulses in the same cycle, without clear, leave data_tube unchanged and data_chg low.
REQ-021 data_tube updates one cycle after the press pulse; data_chg is high in exactly that update cycle and only if the value actually changed (clear at 0 gives no pulse).
REQ-022 data_tube never exceeds MAX_VAL.

Reset
REQ-023 Asserting rst_n low immediately forces data_tube=0, data_chg=0, all FSMs to IDLE, and all debounce/repeat counters and synchronizer flops to their idle (high/0) values.
REQ-024 A key held through reset release produces one press pulse only after a full 2 + DEB_CYCLES cycles from deassertion.
REQ-025 Reset asserted mid-debounce or mid-repeat discards the pending event.

Configuration
REQ-026 Macro KEY_AUTOREPEAT_EN, when defined, makes up/down keys in HELD emit a repeat pulse after RPT_DELAY held cycles and then every RPT_PERIOD cycles until leaving HELD; REL_CHK pauses but does not reset the repeat timer.
REQ-027 Without KEY_AUTOREPEAT_EN, each accepted press yields exactly one pulse, and no repeat counters are instantiated.
REQ-028 The clear key never auto-repeats.

Structure
REQ-029 Shared package tube_pkg holds the debounce state enumeration and the default constants for DEB_CYCLES, RPT_DELAY, and RPT_PERIOD.
REQ-030 Sub-module key_debounce (synchronizer + FSM + optional repeat) is instantiated three times; the top holds only the count register and priority logic.

Verification (DEB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3, MAX_VAL=255)
REQ-031 key_up_n low for 20 cycles, repeat disabled -> single data_chg, data_tube 0->1 at cycle 7 after the falling edge.
REQ-032 key_up_n low for 3 cycles then high (glitch) -> no data_chg, data_tube stays 0.
REQ-033 data_tube=255, press up -> 0; then press down -> 255.
REQ-034 Up and clear accepted in the same cycle with data_tube=5 -> 0; up and down in the same cycle -> unchanged, no data_chg.
REQ-035 KEY_AUTOREPEAT_EN defined, key_up_n held for 30 cycles -> increments at press, then +10, +13, +16, ... cycles, stopping on release.
REQ-036 rst_n pulsed low mid-PRESS_CHK with data_tube=9 -> data_tube 0 at once, no pulse for the aborted press.
